mux_rr_arbiter: RTL and testbench

- Round-robin arbiter and select sequencer for the shared 4-way, 5-bit multiplexer datapath.
- Four requesters (score, snake, target and status sources) compete for the single 5-bit output bus. The block grants one at a time and drives the multiplexer select CTRL to the current owner.
- Sits between the requester logic and the multiplexer. It never touches data, only grant and select.

---
 rtl/mux_rr_arbiter_if.sv | 11 +
 rtl/mux_rr_arbiter.sv | 130 +++++++++++++
 tb/tb_mux_rr_arbiter.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/mux_rr_arbiter_if.sv
// rtl/mux_rr_arbiter_if.sv - request/grant/select bundle between requesters and the bus arbiter
interface mux_rr_arbiter_if;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] ctrl;
  logic       valid;
  logic       preempt;

  modport master (output req, input gnt, input ctrl, input valid, input preempt);
  modport slave  (input req, output gnt, output ctrl, output valid, output preempt);
endinterface

// File: rtl/mux_rr_arbiter.sv
// rtl/mux_rr_arbiter.sv - round-robin grant and mux-select sequencer for the shared 4-way bus
// Optional forced release after HOLD_MAX grant cycles when ARB_TIMEOUT_EN is defined.
module mux_rr_arbiter #(
  parameter int HOLD_MAX = 15,
  parameter int CNT_W    = 4
) (
  input  logic           clk,
  input  logic           reset,
  mux_rr_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  if (2 ** CNT_W <= HOLD_MAX) begin : g_cnt_w_check
    $error("CNT_W too narrow for HOLD_MAX");
  end

  state_t           state, state_nxt;
  logic [3:0]       gnt_q, gnt_nxt;
  logic [1:0]       ctrl_q, ctrl_nxt;
  logic             valid_q, valid_nxt;
  logic             preempt_q, preempt_nxt;
  logic [1:0]       last_q, last_nxt;
  logic [CNT_W-1:0] hold_cnt, hold_cnt_nxt;

  logic       req_any;
  logic       owner_req;
  logic       timeout;
  logic [1:0] winner;
  logic [1:0] idx;

  assign req_any   = |bus.req;
  assign owner_req = bus.req[ctrl_q];

`ifdef ARB_TIMEOUT_EN
  assign timeout = (state == GRANT) && owner_req && (hold_cnt == CNT_W'(HOLD_MAX - 1));
`else
  assign timeout = 1'b0;
`endif

  // Scan from the farthest candidate back to LAST+1 so the nearest requester wins.
  always_comb begin
    winner = last_q;
    idx    = last_q;
    for (int k = 3; k >= 0; k--) begin
      idx = last_q + 2'(k + 1);
      if (bus.req[idx]) begin
        winner = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      gnt_q     <= 4'b0000;
      ctrl_q    <= 2'd0;
      valid_q   <= 1'b0;
      preempt_q <= 1'b0;
      last_q    <= 2'd3;
      hold_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      gnt_q     <= gnt_nxt;
      ctrl_q    <= ctrl_nxt;
      valid_q   <= valid_nxt;
      preempt_q <= preempt_nxt;
      last_q    <= last_nxt;
      hold_cnt  <= hold_cnt_nxt;
    end
  end

  // A release always passes through GAP; there is no direct hand-over.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = req_any ? GRANT : IDLE;
      GRANT:   state_nxt = (!owner_req || timeout) ? GAP : GRANT;
      GAP:     state_nxt = req_any ? GRANT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    gnt_nxt      = gnt_q;
    ctrl_nxt     = ctrl_q;
    valid_nxt    = valid_q;
    preempt_nxt  = 1'b0;
    last_nxt     = last_q;
    hold_cnt_nxt = hold_cnt;
    case (state)
      IDLE, GAP: begin
        if (req_any) begin
          gnt_nxt      = 4'b0001 << winner;
          ctrl_nxt     = winner;
          valid_nxt    = 1'b1;
          last_nxt     = winner;
          hold_cnt_nxt = '0;
        end else begin
          gnt_nxt   = 4'b0000;
          valid_nxt = 1'b0;
        end
      end
      GRANT: begin
        if (!owner_req || timeout) begin
          // CTRL keeps the owner index so the mux output stays put through GAP.
          gnt_nxt     = 4'b0000;
          valid_nxt   = 1'b0;
          preempt_nxt = timeout;
        end else if (hold_cnt != {CNT_W{1'b1}}) begin
          hold_cnt_nxt = hold_cnt + 1'b1;
        end
      end
      default: begin
        gnt_nxt   = 4'b0000;
        valid_nxt = 1'b0;
      end
    endcase
  end

  assign bus.gnt     = gnt_q;
  assign bus.ctrl    = ctrl_q;
  assign bus.valid   = valid_q;
  assign bus.preempt = preempt_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb/tb_mux_rr_arbiter.sv - directed and randomized checks of mux_rr_arbiter against a cycle model
module tb_mux_rr_arbiter;

  localparam int HOLD_MAX = 15;
`ifdef ARB_TIMEOUT_EN
  localparam bit TIMEOUT = 1'b1;
`else
  localparam bit TIMEOUT = 1'b0;
`endif

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  mux_rr_arbiter_if bus ();

  mux_rr_arbiter #(.HOLD_MAX(HOLD_MAX), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: owner index (-1 = none), last winner, cycles held by the current owner.
  int         m_owner;
  int         m_last;
  int         m_held;
  logic [1:0] m_ctrl;
  logic       m_preempt;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic model(input logic [3:0] r, input logic rs);
    bit found;
    int cand;
    if (rs) begin
      m_owner = -1; m_last = 3; m_held = 0; m_ctrl = 2'd0; m_preempt = 1'b0;
    end else begin
      m_preempt = 1'b0;
      if (m_owner >= 0) begin
        if (!r[m_owner]) m_owner = -1;
        else if (TIMEOUT && m_held == HOLD_MAX) begin
          m_owner = -1; m_preempt = 1'b1;
        end else m_held++;
      end else begin
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
          cand = (m_last + k) % 4;
          if (!found && r[cand]) begin
            found = 1'b1; m_owner = cand; m_last = cand; m_ctrl = 2'(cand); m_held = 1;
          end
        end
      end
    end
  endtask

  task automatic step(input logic [3:0] r, input logic rs);
    logic [3:0] eg;
    @(negedge clk);
    bus.req = r;
    reset   = rs;
    @(posedge clk);
    model(r, rs);
    #1;
    eg = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
    check("gnt",     bus.gnt,            eg);
    check("ctrl",    {2'b00, bus.ctrl},  {2'b00, m_ctrl});
    check("valid",   {3'b000, bus.valid},   {3'b000, (m_owner >= 0)});
    check("preempt", {3'b000, bus.preempt}, {3'b000, m_preempt});
  endtask

  logic [3:0] r;
  int         order [5];
  int         run0, run1, npre;

  initial begin
    checks = 0; failures = 0;
    bus.req = 4'b0000; reset = 1'b1;
    order[0] = 0; order[1] = 1; order[2] = 2; order[3] = 3; order[4] = 0;

    // Reset state, single grant, reset mid-grant
    step(4'b0000, 1'b1);
    check("rst_gnt", bus.gnt, 4'b0000);
    check("rst_ctrl", {2'b00, bus.ctrl}, 4'd0);
    step(4'b0100, 1'b0);
    check("grant2_gnt", bus.gnt, 4'b0100);
    check("grant2_ctrl", {2'b00, bus.ctrl}, 4'd2);
    step(4'b0100, 1'b0);
    step(4'b0100, 1'b0);
    step(4'b0100, 1'b1);
    check("midrst_gnt", bus.gnt, 4'b0000);
    check("midrst_valid", {3'b000, bus.valid}, 4'd0);

    // All request; each owner drops for one cycle after three grant cycles
    step(4'b1111, 1'b0);
    for (int g = 0; g < 5; g++) begin
      check("rr_order", bus.gnt, 4'b0001 << order[g]);
      step(4'b1111, 1'b0);
      step(4'b1111, 1'b0);
      r = 4'b1111;
      r[order[g]] = 1'b0;
      step(r, 1'b0);
      check("rr_gap", bus.gnt, 4'b0000);
      step(4'b1111, 1'b0);
    end

    // Owner 1 holds against other requests, then index 2 wins after the gap
    step(4'b0000, 1'b1);
    step(4'b0010, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(4'b1111, 1'b0);
      check("hold_gnt", bus.gnt, 4'b0010);
      check("hold_ctrl", {2'b00, bus.ctrl}, 4'd1);
    end
    step(4'b1101, 1'b0);
    check("drop_gap", bus.gnt, 4'b0000);
    step(4'b1101, 1'b0);
    check("next_is_2", bus.gnt, 4'b0100);

    // Single requester pulsing
    step(4'b0000, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(4'b0001, 1'b0);
      check("single_on", bus.gnt, 4'b0001);
      step(4'b0000, 1'b0);
      check("single_off", bus.gnt, 4'b0000);
      check("single_ctrl", {2'b00, bus.ctrl}, 4'd0);
    end

    // Two requesters held for 100 cycles
    step(4'b0000, 1'b1);
    run0 = 0; run1 = 0; npre = 0;
    for (int i = 0; i < 100; i++) begin
      step(4'b0011, 1'b0);
      if (bus.preempt) npre++;
      if (bus.gnt == 4'b0001 && run1 == 0 && npre == 0) run0++;
      if (bus.gnt == 4'b0010 && npre == 1) run1++;
    end
`ifdef ARB_TIMEOUT_EN
    check("timeout_run0", 4'(run0), 4'(HOLD_MAX));
    check("timeout_run1", 4'(run1), 4'(HOLD_MAX));
`else
    check("noto_run0", 8'(run0) == 8'd100 ? 4'd1 : 4'd0, 4'd1);
    check("noto_preempt", 4'(npre), 4'd0);
`endif

    // Randomized traffic with occasional resets
    step(4'b0000, 1'b1);
    r = 4'b0000;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
      step(r, ($urandom_range(0, 59) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
